// File: rtl/rr_write_arbiter_pkg.sv
// Shared types for the FIFO write arbiter: controller state and grant-index sizing.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_write_arbiter_if.sv
// Writer-side request/busy/data bundle plus the FIFO write side of the arbiter.
interface rr_write_arbiter_if
   import arb_pkg::*;
#(
   parameter int NUM_WRITERS = 4,
   parameter int DATA_W      = 8
) ();

   localparam int ID_W = id_w(NUM_WRITERS);

   logic [NUM_WRITERS*DATA_W-1:0] i_data;
   logic [NUM_WRITERS-1:0]        i_req;
   logic [NUM_WRITERS-1:0]        o_busy;
   logic [DATA_W-1:0]             o_data;
   logic                          o_we;
   logic                          i_fifo_afull;
   logic [ID_W-1:0]               o_grant_id;
   logic                          o_grant_valid;

   modport master (
      input  i_data, i_req, i_fifo_afull,
      output o_busy, o_data, o_we, o_grant_id, o_grant_valid
   );

   modport slave (
      output i_data, i_req, i_fifo_afull,
      input  o_busy, o_data, o_we, o_grant_id, o_grant_valid
   );

endinterface

// File: rtl/rr_write_arbiter_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping at NUM_WRITERS.
module rr_pick
   import arb_pkg::*;
#(
   parameter  int NUM_WRITERS = 4,
   localparam int ID_W        = id_w(NUM_WRITERS)
) (
   input  logic [NUM_WRITERS-1:0] req,
   input  logic [ID_W-1:0]        ptr,
   output logic [ID_W-1:0]        winner,
   output logic                   any_req
);

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int k = 0; k < NUM_WRITERS; k++) begin
         int idx;
         // Explicit wrap so non-power-of-two writer counts never index past the end.
         idx = int'(ptr) + k;
         if (idx >= NUM_WRITERS) idx = idx - NUM_WRITERS;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_WRITERS writers,
// with bursts of up to MAX_BURST beats per grant and almost-full backpressure.
module rr_write_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_WRITERS = 4,
   parameter int DATA_W      = 8,
   parameter int MAX_BURST   = 4
) (
   input logic                 i_clk,
   input logic                 i_reset,
   rr_write_arbiter_if.master  bus
);

   localparam int ID_W   = id_w(NUM_WRITERS);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state;
   logic [BEAT_W-1:0] beats;
   logic [ID_W-1:0]   ptr;

   logic [ID_W-1:0]   winner;
   logic              any_req;
   logic              accept;
   logic              more;
   logic [ID_W-1:0]   ptr_nxt;
   logic [DATA_W-1:0] grant_data;

   rr_pick #(
      .NUM_WRITERS (NUM_WRITERS)
   ) u_pick (
      .req     (bus.i_req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // In GRANT the grantee's busy bit is always low, so its request alone means a beat is taken.
   assign accept     = bus.i_req[bus.o_grant_id];
   assign grant_data = bus.i_data[bus.o_grant_id*DATA_W +: DATA_W];
   assign more       = accept && ((int'(beats) + 1) < MAX_BURST) && !bus.i_fifo_afull;
   assign ptr_nxt    = (bus.o_grant_id == ID_W'(NUM_WRITERS - 1)) ? '0
                                                                  : bus.o_grant_id + ID_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state             <= IDLE;
         beats             <= '0;
         ptr               <= '0;
         bus.o_busy        <= '1;
         bus.o_we          <= 1'b0;
         bus.o_data        <= '0;
         bus.o_grant_id    <= '0;
         bus.o_grant_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.o_we <= 1'b0;
               if (any_req && !bus.i_fifo_afull) begin
                  bus.o_busy        <= ~(NUM_WRITERS'(1) << winner);
                  bus.o_grant_id    <= winner;
                  bus.o_grant_valid <= 1'b1;
                  beats             <= '0;
                  state             <= GRANT;
               end
            end

            GRANT: begin
               if (accept) begin
                  bus.o_data <= grant_data;
                  bus.o_we   <= 1'b1;
                  beats      <= beats + BEAT_W'(1);
               end else begin
                  bus.o_we   <= 1'b0;
               end
               // Ending always passes through one all-busy IDLE cycle, even if the same writer wins next.
               if (!more) begin
                  bus.o_busy        <= '1;
                  bus.o_grant_valid <= 1'b0;
                  ptr               <= ptr_nxt;
                  state             <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_write_arbiter.sv
// Directed bench for rr_write_arbiter: stimulus pushes expected FIFO writes, monitors pop and compare.
module tb_rr_write_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst;

   int errors = 0;
   int checks = 0;

   wr_t qa[$];
   wr_t qb[$];
   wr_t sa;
   wr_t sb;

   logic [3:0] tb3_busy [11];
   logic       tb3_we   [11];

   always #5 clk = ~clk;

   rr_write_arbiter_if #(.NUM_WRITERS(4), .DATA_W(8)) ifa ();
   rr_write_arbiter_if #(.NUM_WRITERS(4), .DATA_W(8)) ifb ();

   rr_write_arbiter #(.NUM_WRITERS(4), .DATA_W(8), .MAX_BURST(4)) dut_a (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ifa)
   );

   rr_write_arbiter #(.NUM_WRITERS(4), .DATA_W(8), .MAX_BURST(1)) dut_b (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (ifb)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance one cycle, then compare busy/we/grant_valid of the selected instance.
   task automatic cyc(input bit use_b, input string nm, input logic [3:0] e_busy,
                      input logic e_we, input logic e_gv);
      step();
      if (use_b) begin
         chk({nm, "_busy"}, 32'(ifb.o_busy), 32'(e_busy));
         chk({nm, "_we"},   32'(ifb.o_we),   32'(e_we));
      end else begin
         chk({nm, "_busy"}, 32'(ifa.o_busy),        32'(e_busy));
         chk({nm, "_we"},   32'(ifa.o_we),          32'(e_we));
         chk({nm, "_gv"},   32'(ifa.o_grant_valid), 32'(e_gv));
      end
   endtask

   always @(negedge clk) begin
      if (ifa.o_we === 1'b1) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_a: got write id=%0d data=%0h expected no write", ifa.o_grant_id, ifa.o_data);
         end else begin
            sa = qa.pop_front();
            chk("sb_a_data", 32'(ifa.o_data), 32'(sa.d));
            chk("sb_a_id",   32'(ifa.o_grant_id), 32'(sa.id));
         end
      end
      if (ifb.o_we === 1'b1) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_b: got write id=%0d data=%0h expected no write", ifb.o_grant_id, ifb.o_data);
         end else begin
            sb = qb.pop_front();
            chk("sb_b_data", 32'(ifb.o_data), 32'(sb.d));
            chk("sb_b_id",   32'(ifb.o_grant_id), 32'(sb.id));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifa.i_req = '0; ifa.i_data = '0; ifa.i_fifo_afull = 1'b0;
      ifb.i_req = '0; ifb.i_data = '0; ifb.i_fifo_afull = 1'b0;
      tb3_busy = '{4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111,
                   4'b0111, 4'b1111, 4'b1110, 4'b1111, 4'b1111};
      tb3_we   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset held two cycles with every writer requesting
      ifa.i_req = 4'hF;
      ifb.i_req = 4'hF;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_busy_a", 32'(ifa.o_busy), 32'hF);
         chk("rst_we_a",   32'(ifa.o_we), 32'h0);
         chk("rst_data_a", 32'(ifa.o_data), 32'h0);
         chk("rst_gv_a",   32'(ifa.o_grant_valid), 32'h0);
         chk("rst_busy_b", 32'(ifb.o_busy), 32'hF);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rel_busy_a", 32'(ifa.o_busy), 32'hF);
      chk("rel_we_a",   32'(ifa.o_we), 32'h0);
      chk("rel_gv_a",   32'(ifa.o_grant_valid), 32'h0);
      ifa.i_req = '0;
      ifb.i_req = '0;
      step();
      chk("idle_busy_a", 32'(ifa.o_busy), 32'hF);

      // Single writer 2, two beats with a data change between them
      ifa.i_data[23:16] = 8'hA5;
      ifa.i_req = 4'b0100;
      qa.push_back('{id: 2'd2, d: 8'hA5});
      qa.push_back('{id: 2'd2, d: 8'h5A});
      cyc(0, "t2c1", 4'b1011, 1'b0, 1'b1);
      chk("t2_gid", 32'(ifa.o_grant_id), 32'd2);
      cyc(0, "t2c2", 4'b1011, 1'b1, 1'b1);
      ifa.i_data[23:16] = 8'h5A;
      cyc(0, "t2c3", 4'b1011, 1'b1, 1'b1);
      ifa.i_req = '0;
      cyc(0, "t2c4", 4'b1111, 1'b0, 1'b0);
      chk("t2_ptr", 32'(dut_a.ptr), 32'd3);

      // Burst limit: writer 1 alone, four beats then a forced all-busy cycle
      ifa.i_data[15:8] = 8'h3C;
      ifa.i_req = 4'b0010;
      for (int i = 0; i < 4; i++) qa.push_back('{id: 2'd1, d: 8'h3C});
      cyc(0, "t4c1", 4'b1101, 1'b0, 1'b1);
      cyc(0, "t4c2", 4'b1101, 1'b1, 1'b1);
      cyc(0, "t4c3", 4'b1101, 1'b1, 1'b1);
      cyc(0, "t4c4", 4'b1101, 1'b1, 1'b1);
      cyc(0, "t4c5", 4'b1111, 1'b1, 1'b0);
      cyc(0, "t4c6", 4'b1101, 1'b0, 1'b1);
      chk("t4_gid", 32'(ifa.o_grant_id), 32'd1);
      ifa.i_req = '0;
      cyc(0, "t4c7", 4'b1111, 1'b0, 1'b0);
      chk("t4_ptr", 32'(dut_a.ptr), 32'd2);

      // Backpressure: afull during beat 2 of writer 3; writer 1 waits and wins afterwards
      ifa.i_data[31:24] = 8'h77;
      ifa.i_data[15:8]  = 8'h99;
      ifa.i_req = 4'b1010;
      qa.push_back('{id: 2'd3, d: 8'h77});
      qa.push_back('{id: 2'd3, d: 8'h77});
      cyc(0, "t5c1", 4'b0111, 1'b0, 1'b1);
      chk("t5_gid3", 32'(ifa.o_grant_id), 32'd3);
      cyc(0, "t5c2", 4'b0111, 1'b1, 1'b1);
      ifa.i_fifo_afull = 1'b1;
      cyc(0, "t5c3", 4'b1111, 1'b1, 1'b0);
      cyc(0, "t5c4", 4'b1111, 1'b0, 1'b0);
      chk("t5_hold", 32'(ifa.o_data), 32'h77);
      cyc(0, "t5c5", 4'b1111, 1'b0, 1'b0);
      ifa.i_fifo_afull = 1'b0;
      cyc(0, "t5c6", 4'b1101, 1'b0, 1'b1);
      chk("t5_gid1", 32'(ifa.o_grant_id), 32'd1);
      ifa.i_req = '0;
      cyc(0, "t5c7", 4'b1111, 1'b0, 1'b0);

      // Reset after the first beat of writer 0's burst
      ifa.i_data[7:0] = 8'h42;
      ifa.i_req = 4'b0001;
      qa.push_back('{id: 2'd0, d: 8'h42});
      cyc(0, "t6c1", 4'b1110, 1'b0, 1'b1);
      cyc(0, "t6c2", 4'b1110, 1'b1, 1'b1);
      rst = 1'b1;
      ifa.i_req = '0;
      cyc(0, "t6c3", 4'b1111, 1'b0, 1'b0);
      chk("t6_data", 32'(ifa.o_data), 32'h0);
      chk("t6_ptr",  32'(dut_a.ptr), 32'd0);
      rst = 1'b0;

      // Single-beat grants, all four requesting: order 0,1,2,3,0
      ifb.i_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
      ifb.i_req = 4'hF;
      qb.push_back('{id: 2'd0, d: 8'hB0});
      qb.push_back('{id: 2'd1, d: 8'hB1});
      qb.push_back('{id: 2'd2, d: 8'hB2});
      qb.push_back('{id: 2'd3, d: 8'hB3});
      qb.push_back('{id: 2'd0, d: 8'hB0});
      for (int i = 0; i < 11; i++) begin
         cyc(1, $sformatf("t3c%0d", i + 1), tb3_busy[i], tb3_we[i], 1'b0);
         if (i == 9) ifb.i_req = '0;
      end

      step();
      step();
      chk("sb_a_left", 32'(qa.size()), 32'd0);
      chk("sb_b_left", 32'(qb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
